muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage, and the successor to the fixed 32-bit start/ready divider. It accepts one signed or unsigned MULT/DIV operation per handshake and computes it over a bounded number of cycles at a configurable radix. It returns the HI/LO pair with a one-cycle valid pulse and can be annulled mid-operation on flush. EX holds its stall request while `busy` is high.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_iter_if.sv | 26 ++
 rtl/div_step.sv | 48 ++++
 rtl/muldiv_iter.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op and state encodings for the iterative
// multiply/divide unit (muldiv_iter) and its bench.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_signed(
    input logic [1:0] op
  );
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_mul(
    input logic [1:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if: request/response bundle between EX and
// the iterative multiply/divide unit.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             annul;
  logic             ready;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, annul,
    input  ready, busy, result_valid, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, annul,
    output ready, busy, result_valid, hi, lo
  );
endinterface

// File: rtl/div_step.sv
// div_step: STEP restoring-subtract iterations on the
// {remainder, dividend} pair plus the shared iteration counter.
module div_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CW    = 5
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  input  logic [CW-1:0]    i_cnt,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo,
  output logic [CW-1:0]    o_cnt,
  output logic             o_last
);
  localparam int N = WIDTH / STEP;

  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_dif;

  always_comb begin
    w_rem = i_rem;
    w_quo = i_quo;
    w_sh  = '0;
    w_dif = '0;
    for (int s = 0; s < STEP; s++) begin
      w_sh  = {w_rem[WIDTH-1:0], w_quo[WIDTH-1]};
      w_quo = {w_quo[WIDTH-2:0], 1'b0};
      w_dif = {1'b0, w_sh} - {2'b00, i_div};
      // No borrow: the divisor fits, keep the difference
      if (!w_dif[WIDTH+1]) begin
        w_rem    = w_dif[WIDTH:0];
        w_quo[0] = 1'b1;
      end else begin
        w_rem = w_sh;
      end
    end
  end

  assign o_rem  = w_rem;
  assign o_quo  = w_quo;
  assign o_cnt  = i_cnt + 1'b1;
  assign o_last = (i_cnt == CW'(N - 1));

endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned MULT/DIV for EX.
// Define MULDIV_FAST_MUL_EN for a single-stage multiplier path.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  muldiv_iter_if.slave io
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N);
  localparam int W2 = 2 * WIDTH;

  md_state_e        r_state;
  md_state_e        w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;
  logic [W2:0]      r_acc;
  logic [W2:0]      w_acc_init;
  logic [W2:0]      w_acc_nxt;
  logic [W2:0]      w_mul_acc;
  logic [WIDTH-1:0] r_opd;
  logic             r_mul;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_valid;

  logic             w_ready;
  logic             w_busy;
  logic             w_accept;
  logic             w_wr;
  logic             w_sgn;
  logic             w_mul;
  logic             w_fast;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [W2-1:0]    w_p;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_sgn = md_is_signed(io.op);
  assign w_mul = md_is_mul(io.op);

  assign w_abs_a = (w_sgn & io.src_a[WIDTH-1]) ?
                   -io.src_a : io.src_a;
  assign w_abs_b = (w_sgn & io.src_b[WIDTH-1]) ?
                   -io.src_b : io.src_b;

`ifdef MULDIV_FAST_MUL_EN
  assign w_fast = w_mul;
`else
  assign w_fast = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= MD_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_ready  = (r_state == MD_IDLE);
    w_busy   = (r_state == MD_CALC) ||
               (r_state == MD_FIX);
    w_accept = io.start & w_ready & ~io.annul;
    w_wr     = (r_state == MD_FIX) & ~io.annul;
    unique case (r_state)
      MD_IDLE: if (w_accept)
                 w_nxt = w_fast ? MD_FIX : MD_CALC;
      MD_CALC: if (w_last) w_nxt = MD_FIX;
      MD_FIX:  w_nxt = MD_IDLE;
      default: w_nxt = MD_IDLE;
    endcase
    if (io.annul) w_nxt = MD_IDLE;
  end

  // MUL keeps |b| in the low half, DIV keeps |a| there
  always_comb begin
    w_acc_init = '0;
    w_acc_init[WIDTH-1:0] = w_mul ? w_abs_b : w_abs_a;
`ifdef MULDIV_FAST_MUL_EN
    if (w_mul)
      w_acc_init = {1'b0, W2'(w_abs_a) * W2'(w_abs_b)};
`endif
  end

  always_comb begin
    w_mul_acc = {1'b0, r_acc[W2-1:0]};
    for (int s = 0; s < STEP; s++) begin
      if (w_mul_acc[0])
        w_mul_acc[W2:WIDTH] = w_mul_acc[W2:WIDTH] +
                              {1'b0, r_opd};
      w_mul_acc = w_mul_acc >> 1;
    end
  end

  div_step #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .CW   (CW)
  ) u_div_step (
    .i_rem (r_acc[W2:WIDTH]),
    .i_quo (r_acc[WIDTH-1:0]),
    .i_div (r_opd),
    .i_cnt (r_cnt),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo),
    .o_cnt (w_cnt_nxt),
    .o_last(w_last)
  );

  assign w_acc_nxt = r_mul ? w_mul_acc :
                     {w_div_rem, w_div_quo};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mul   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_opd   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_mul   <= w_mul;
      r_neg_q <= w_sgn &
                 (io.src_a[WIDTH-1] ^ io.src_b[WIDTH-1]);
      r_neg_r <= w_sgn & io.src_a[WIDTH-1];
      r_dz    <= ~w_mul & (io.src_b == '0);
      r_opd   <= w_mul ? w_abs_a : w_abs_b;
      r_acc   <= w_acc_init;
      r_cnt   <= '0;
    end else if (r_state == MD_CALC) begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_p    = r_acc[W2-1:0];
  assign w_prod = r_neg_q ? -w_p : w_p;

  // Divide by zero forces an all-ones quotient for both signs
  assign w_q = r_dz    ? '1 :
               r_neg_q ? -r_acc[WIDTH-1:0] :
                         r_acc[WIDTH-1:0];
  assign w_r = r_neg_r ? -r_acc[W2-1:WIDTH] :
                         r_acc[W2-1:WIDTH];

  assign w_hi = r_mul ? w_prod[W2-1:WIDTH] : w_r;
  assign w_lo = r_mul ? w_prod[WIDTH-1:0]  : w_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_valid <= w_wr;
      if (w_wr) begin
        r_hi <= w_hi;
        r_lo <= w_lo;
      end
    end
  end

  assign io.ready        = w_ready;
  assign io.busy         = w_busy;
  assign io.result_valid = r_valid;
  assign io.hi           = r_hi;
  assign io.lo           = r_lo;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed + random checks of muldiv_iter
// (32-bit STEP=1 and 16-bit STEP=2 instances).
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic clk;
  logic resetn;
  int   n_chk;
  int   n_err;

  muldiv_iter_if #(.WIDTH(32)) ia ();
  muldiv_iter_if #(.WIDTH(16)) ib ();

  muldiv_iter #(.WIDTH(32), .STEP(1)) u_a (
    .clk   (clk),
    .resetn(resetn),
    .io    (ia)
  );

  muldiv_iter #(.WIDTH(16), .STEP(2)) u_b (
    .clk   (clk),
    .resetn(resetn),
    .io    (ib)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on sign-extended operands
  function automatic void model(input int w,
                                input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi,
                                output logic [31:0] lo);
    longint unsigned mask, ua, ub, up;
    longint sa, sb, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    up = 0;
    case (op)
      MD_MULT:  up = sa * sb;
      MD_MULTU: up = ua * ub;
      MD_DIV: begin
        if (ub == 0) up = (ua << w) | mask;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          up = ((sr & mask) << w) | (sq & mask);
        end
      end
      default: begin
        if (ub == 0) up = (ua << w) | mask;
        else up = ((ua % ub) << w) | (ua / ub);
      end
    endcase
    hi = 32'((up >> w) & mask);
    lo = 32'(up & mask);
  endfunction

  function automatic int lat_of(input int d,
                                input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (op == MD_MULT || op == MD_MULTU) return 2;
`endif
    return (d != 0) ? 10 : 34;
  endfunction

  task automatic issue(input int d, input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    if (d == 0) begin
      ia.start = 1'b1; ia.op = op;
      ia.src_a = a;    ia.src_b = b;
    end else begin
      ib.start = 1'b1; ib.op = op;
      ib.src_a = a[15:0]; ib.src_b = b[15:0];
    end
  endtask

  task automatic sample(input int d,
                        output logic rdy, output logic bsy,
                        output logic vld,
                        output logic [31:0] hi,
                        output logic [31:0] lo);
    if (d == 0) begin
      rdy = ia.ready; bsy = ia.busy; vld = ia.result_valid;
      hi = ia.hi; lo = ia.lo;
    end else begin
      rdy = ib.ready; bsy = ib.busy; vld = ib.result_valid;
      hi = {16'h0, ib.hi}; lo = {16'h0, ib.lo};
    end
  endtask

  // Returns at the negedge of the result_valid cycle
  task automatic finish_op(input int d, input string tag,
                           input int lat,
                           input logic [31:0] eh,
                           input logic [31:0] el);
    int cyc;
    logic got, rdy, bsy, vld;
    logic [31:0] hi, lo;
    cyc = 0; got = 1'b0;
    rdy = 0; bsy = 0; vld = 0; hi = 0; lo = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      sample(d, rdy, bsy, vld, hi, lo);
      if (cyc == 1) begin
        if (d == 0) begin
          ia.start = 1'b0;
          ia.src_a = $urandom; ia.src_b = $urandom;
        end else begin
          ib.start = 1'b0;
          ib.src_a = 16'($urandom); ib.src_b = 16'($urandom);
        end
        chk({tag, ":busy"}, 64'(bsy), 64'd1);
        chk({tag, ":pulse"}, 64'(vld), 64'd0);
      end
      got = vld;
    end
    chk({tag, ":lat"}, got ? 64'(cyc) : 64'd0, 64'(lat));
    chk({tag, ":hi"}, 64'(hi), 64'(eh));
    chk({tag, ":lo"}, 64'(lo), 64'(el));
    chk({tag, ":ready"}, 64'(rdy), 64'd1);
  endtask

  task automatic run_exp(input int d, input string tag,
                         input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eh,
                         input logic [31:0] el);
    issue(d, op, a, b);
    finish_op(d, tag, lat_of(d, op), eh, el);
  endtask

  task automatic run_rnd(input int d, input string tag);
    logic [1:0] op;
    logic [31:0] a, b, eh, el;
    int sel;
    op  = 2'($urandom_range(0, 3));
    a   = $urandom;
    b   = $urandom;
    sel = $urandom_range(0, 7);
    if (d != 0) begin a[31:16] = 0; b[31:16] = 0; end
    case (sel)
      0: b = 0;
      1: begin
        a = (d != 0) ? 32'h8000 : 32'h8000_0000;
        b = (d != 0) ? 32'hFFFF : 32'hFFFF_FFFF;
      end
      2: b = $urandom_range(1, 15);
      default: ;
    endcase
    model((d != 0) ? 16 : 32, op, a, b, eh, el);
    run_exp(d, tag, op, a, b, eh, el);
  endtask

  task automatic watch(input int d, input int n,
                       output int nv);
    logic rdy, bsy, vld;
    logic [31:0] hi, lo;
    nv = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sample(d, rdy, bsy, vld, hi, lo);
      if (vld) nv++;
    end
  endtask

  initial begin
    logic rdy, bsy, vld;
    logic [31:0] hi, lo;
    int nv;
    n_chk = 0; n_err = 0;
    clk = 1'b0; resetn = 1'b0;
    ia.start = 0; ia.annul = 0; ia.op = 0;
    ia.src_a = 0; ia.src_b = 0;
    ib.start = 0; ib.annul = 0; ib.op = 0;
    ib.src_a = 0; ib.src_b = 0;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sample(d, rdy, bsy, vld, hi, lo);
      chk("rst:ready", 64'(rdy), 64'd1);
      chk("rst:busy",  64'(bsy), 64'd0);
      chk("rst:valid", 64'(vld), 64'd0);
      chk("rst:hi",    64'(hi),  64'd0);
      chk("rst:lo",    64'(lo),  64'd0);
    end
    resetn = 1'b1;
    @(negedge clk);

    run_exp(0, "divu", MD_DIVU, 100, 7, 2, 14);
    run_exp(0, "div_neg", MD_DIV, 32'hFFFF_FFF9, 2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_exp(0, "mult_min", MD_MULT, 32'h8000_0000,
            32'h8000_0000, 32'h4000_0000, 0);
    run_exp(0, "divu_dz", MD_DIVU, 32'h1234_5678, 0,
            32'h1234_5678, 32'hFFFF_FFFF);
    run_exp(0, "div_ovf", MD_DIV, 32'h8000_0000,
            32'hFFFF_FFFF, 0, 32'h8000_0000);
    run_exp(0, "div_dz_neg", MD_DIV, 32'hFFFF_FF00, 0,
            32'hFFFF_FF00, 32'hFFFF_FFFF);
    run_exp(0, "mult_neg", MD_MULT, 32'hFFFF_FFFD, 5,
            32'hFFFF_FFFF, 32'hFFFF_FFF1);

    issue(0, MD_DIV, 1000, 3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) ia.start = 1'b0;
      if (k == 10) ia.annul = 1'b1;
    end
    @(negedge clk);
    ia.annul = 1'b0;
    sample(0, rdy, bsy, vld, hi, lo);
    chk("annul:ready", 64'(rdy), 64'd1);
    chk("annul:busy",  64'(bsy), 64'd0);
    watch(0, 40, nv);
    chk("annul:novalid", 64'(nv), 64'd0);
    sample(0, rdy, bsy, vld, hi, lo);
    chk("annul:hi", 64'(hi), 64'hFFFF_FFFF);
    chk("annul:lo", 64'(lo), 64'hFFFF_FFF1);
    run_exp(0, "multu_after", MD_MULTU, 3, 5, 0, 15);

    issue(0, MD_DIVU, 50, 5);
    ia.annul = 1'b1;
    @(negedge clk);
    ia.start = 1'b0; ia.annul = 1'b0;
    sample(0, rdy, bsy, vld, hi, lo);
    chk("annul_start:busy",  64'(bsy), 64'd0);
    chk("annul_start:ready", 64'(rdy), 64'd1);
    watch(0, 40, nv);
    chk("annul_start:novalid", 64'(nv), 64'd0);
    sample(0, rdy, bsy, vld, hi, lo);
    chk("annul_start:lo", 64'(lo), 64'd15);

    for (int i = 0; i < 24; i++) run_rnd(0, "rnd32");

    run_exp(1, "divu16", MD_DIVU, 32'hFFFF, 32'h0100,
            32'h00FF, 32'h00FF);
    run_exp(1, "div16_neg", MD_DIV, 32'hFFF9, 2,
            32'hFFFF, 32'hFFFD);

    issue(1, MD_DIVU, 32'h7777, 3);
    repeat (3) begin
      @(negedge clk);
      ib.start = 1'b0;
    end
    #2 resetn = 1'b0;
    #1;
    sample(1, rdy, bsy, vld, hi, lo);
    chk("midrst:ready", 64'(rdy), 64'd1);
    chk("midrst:busy",  64'(bsy), 64'd0);
    chk("midrst:valid", 64'(vld), 64'd0);
    chk("midrst:hi",    64'(hi),  64'd0);
    chk("midrst:lo",    64'(lo),  64'd0);
    @(negedge clk);
    resetn = 1'b1;
    watch(1, 15, nv);
    chk("midrst:novalid", 64'(nv), 64'd0);

    for (int i = 0; i < 12; i++) run_rnd(1, "rnd16");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
